// File: rtl/traffic_phase_sched.sv
// traffic_phase_sched: two-approach intersection phase scheduler.
// Sequences G/Y/all-red intervals for approach 1 (N/S) and approach 2 (E/W)
// from runtime-programmable tick counts, serves vehicle and latched
// pedestrian requests, and drives the lamp and walk outputs.
// Optional build macro: TRAFFIC_FLASH_EN adds a 'flash' input and a
// flashing-yellow FLASH mode (reported as phase 0 with an internal flag).
module traffic_phase_sched #(
   parameter int TW         = 8,
   parameter int DEF_GREEN  = 20,
   parameter int DEF_YELLOW = 4,
   parameter int DEF_ALLRED = 2,
   parameter int DEF_WALK   = 10
) (
   input  logic          clk,
   input  logic          rst,
`ifdef TRAFFIC_FLASH_EN
   input  logic          flash,
`endif
   input  logic          cfg_load,
   input  logic [TW-1:0] Tgreen,
   input  logic [TW-1:0] Tyellow,
   input  logic [TW-1:0] Tallred,
   input  logic [TW-1:0] Twalk,
   input  logic          req1,
   input  logic          req2,
   input  logic          ped_req,
   output logic          R1,
   output logic          Y1,
   output logic          G1,
   output logic          R2,
   output logic          Y2,
   output logic          G2,
   output logic          walk,
   output logic          ped_pending,
   output logic [2:0]    phase
);

   localparam logic [2:0] S_INIT = 3'd0;
   localparam logic [2:0] S_G1   = 3'd1;
   localparam logic [2:0] S_Y1   = 3'd2;
   localparam logic [2:0] S_AR1  = 3'd3;
   localparam logic [2:0] S_G2   = 3'd4;
   localparam logic [2:0] S_Y2   = 3'd5;
   localparam logic [2:0] S_AR2  = 3'd6;
   localparam logic [2:0] S_WALK = 3'd7;

   // Lamp pattern {R1,Y1,G1,R2,Y2,G2} while all approaches are held red.
   localparam logic [5:0] L_ALLRED = 6'b100100;

   // Last counter value of an interval of programmed length t (0 acts as 1).
   function automatic logic [TW-1:0] f_last(input logic [TW-1:0] t);
      return (t == '0) ? '0 : t - TW'(1);
   endfunction

   // Lamp decode {R1,Y1,G1,R2,Y2,G2} for a sequencing state.
   function automatic logic [5:0] f_lamps(input logic [2:0] s);
      case (s)
         S_G1:    return 6'b001100;
         S_Y1:    return 6'b010100;
         S_G2:    return 6'b100001;
         S_Y2:    return 6'b100010;
         default: return L_ALLRED;
      endcase
   endfunction

   logic [2:0]    r_state;
   logic [TW-1:0] r_cnt;
   logic [TW-1:0] r_sh_green, r_sh_yellow, r_sh_allred, r_sh_walk;
   logic [TW-1:0] r_act_green, r_act_yellow, r_act_allred, r_act_walk;
   logic          r_last_dir;   // 0: approach 1 had green last, 1: approach 2
   logic          r_ped;
   logic [5:0]    r_lamps;
   logic          r_walk;
`ifdef TRAFFIC_FLASH_EN
   logic          r_flash;
   logic          r_fy;
   logic          w_nxt_flash;
   logic          w_nxt_fy;
`endif

   logic [2:0]    w_nxt_state;
   logic          w_restart;
   logic          w_load;
   logic          w_g_rdy1;
   logic          w_g_rdy2;
   logic          w_ped_clr;
   logic          w_ped_set;

   // Next-state selection, counter restart and active-timing reload decision.
   always_comb begin
      w_nxt_state = r_state;
      w_g_rdy1    = (r_cnt >= f_last(r_act_green)) && (req2 || r_ped);
      w_g_rdy2    = (r_cnt >= f_last(r_act_green)) && (req1 || r_ped);
      case (r_state)
         S_INIT: if (r_cnt == f_last(r_act_allred)) w_nxt_state = S_G1;
         S_G1:   if (w_g_rdy1) w_nxt_state = S_Y1;
         S_Y1:   if (r_cnt == f_last(r_act_yellow)) w_nxt_state = S_AR1;
         S_AR1:  if (r_cnt == f_last(r_act_allred)) w_nxt_state = r_ped ? S_WALK : S_G2;
         S_G2:   if (w_g_rdy2) w_nxt_state = S_Y2;
         S_Y2:   if (r_cnt == f_last(r_act_yellow)) w_nxt_state = S_AR2;
         S_AR2:  if (r_cnt == f_last(r_act_allred)) w_nxt_state = r_ped ? S_WALK : S_G1;
         S_WALK: if (r_cnt == f_last(r_act_walk)) w_nxt_state = r_last_dir ? S_G1 : S_G2;
         default: w_nxt_state = S_INIT;
      endcase
      w_restart = (w_nxt_state != r_state);
      w_ped_clr = w_restart && (w_nxt_state == S_WALK);
      w_ped_set = ped_req && (r_state != S_WALK);
`ifdef TRAFFIC_FLASH_EN
      // Flash overrides sequencing; the yellow blink reuses the interval
      // counter against the active yellow time.
      w_nxt_flash = 1'b0;
      w_nxt_fy    = r_fy;
      if (flash) begin
         w_nxt_flash = 1'b1;
         w_nxt_state = S_INIT;
         if (!r_flash) begin
            w_nxt_fy  = 1'b1;
            w_restart = 1'b1;
         end else if (r_cnt == f_last(r_act_yellow)) begin
            w_nxt_fy  = ~r_fy;
            w_restart = 1'b1;
         end else begin
            w_restart = 1'b0;
         end
      end else if (r_flash) begin
         w_nxt_state = S_INIT;
         w_nxt_fy    = 1'b0;
         w_restart   = 1'b1;
      end
      w_ped_clr = w_ped_clr || w_nxt_flash;
      w_ped_set = w_ped_set && !r_flash;
`endif
      w_load = w_restart && ((w_nxt_state == S_INIT) || (w_nxt_state == S_AR1) ||
                             (w_nxt_state == S_AR2));
`ifdef TRAFFIC_FLASH_EN
      w_load = w_load && !w_nxt_flash;
`endif
   end

   // State register and interval counter (saturates while a green rests).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_INIT;
         r_cnt   <= '0;
      end else begin
         r_state <= w_nxt_state;
         if (w_restart)
            r_cnt <= '0;
         else if (r_cnt != '1)
            r_cnt <= r_cnt + TW'(1);
      end
   end

`ifdef TRAFFIC_FLASH_EN
   // Flash mode flag and blinking-yellow phase.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_flash <= 1'b0;
         r_fy    <= 1'b0;
      end else begin
         r_flash <= w_nxt_flash;
         r_fy    <= w_nxt_fy;
      end
   end
`endif

   // Remembers which approach last had green, for the exit from WALK.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_last_dir <= 1'b0;
      else if (w_restart && (w_nxt_state == S_AR1))
         r_last_dir <= 1'b0;
      else if (w_restart && (w_nxt_state == S_AR2))
         r_last_dir <= 1'b1;
   end

   // Latched pedestrian request; cleared when WALK is entered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_ped <= 1'b0;
      else if (w_ped_clr)
         r_ped <= 1'b0;
      else if (w_ped_set)
         r_ped <= 1'b1;
   end

   // Shadow timing registers written by the configuration strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sh_green  <= TW'(DEF_GREEN);
         r_sh_yellow <= TW'(DEF_YELLOW);
         r_sh_allred <= TW'(DEF_ALLRED);
         r_sh_walk   <= TW'(DEF_WALK);
      end else if (cfg_load) begin
         r_sh_green  <= Tgreen;
         r_sh_yellow <= Tyellow;
         r_sh_allred <= Tallred;
         r_sh_walk   <= Twalk;
      end
   end

   // Active timing, refreshed only at INIT/all-red entry so a running
   // interval always finishes with the length it started with.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_act_green  <= TW'(DEF_GREEN);
         r_act_yellow <= TW'(DEF_YELLOW);
         r_act_allred <= TW'(DEF_ALLRED);
         r_act_walk   <= TW'(DEF_WALK);
      end else if (w_load) begin
         r_act_green  <= r_sh_green;
         r_act_yellow <= r_sh_yellow;
         r_act_allred <= r_sh_allred;
         r_act_walk   <= r_sh_walk;
      end
   end

   // Registered lamp outputs, decoded from the next state so they change
   // on the same edge as the state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lamps <= L_ALLRED;
         r_walk  <= 1'b0;
      end else begin
         r_lamps <= f_lamps(w_nxt_state);
         r_walk  <= (w_nxt_state == S_WALK);
`ifdef TRAFFIC_FLASH_EN
         if (w_nxt_flash) begin
            r_lamps <= {1'b0, w_nxt_fy, 1'b0, 1'b0, w_nxt_fy, 1'b0};
            r_walk  <= 1'b0;
         end
`endif
      end
   end

   assign {R1, Y1, G1, R2, Y2, G2} = r_lamps;
   assign walk        = r_walk;
   assign ped_pending = r_ped;
   assign phase       = r_state;

endmodule

// File: tb/tb_traffic_phase_sched.sv
// Testbench for traffic_phase_sched. Expected phase segments (phase, length)
// are queued as each scenario is driven; a negedge monitor closes a segment
// whenever the phase changes and compares it against the queue head.
module tb_traffic_phase_sched;

   logic       clk = 1'b0;
   logic       rst;
`ifdef TRAFFIC_FLASH_EN
   logic       flash;
`endif
   logic       cfg_load;
   logic [7:0] Tgreen, Tyellow, Tallred, Twalk;
   logic       req1, req2, ped_req;
   logic       R1, Y1, G1, R2, Y2, G2, walk, ped_pending;
   logic [2:0] phase;

   typedef struct {
      int ph;
      int len;
   } seg_t;

   seg_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   int   mon_en = 0;
   int   mon_phase = 0;
   int   mon_len = 0;
   int   mon_lamps = 0;

   traffic_phase_sched dut (
      .clk         (clk),
      .rst         (rst),
`ifdef TRAFFIC_FLASH_EN
      .flash       (flash),
`endif
      .cfg_load    (cfg_load),
      .Tgreen      (Tgreen),
      .Tyellow     (Tyellow),
      .Tallred     (Tallred),
      .Twalk       (Twalk),
      .req1        (req1),
      .req2        (req2),
      .ped_req     (ped_req),
      .R1          (R1),
      .Y1          (Y1),
      .G1          (G1),
      .R2          (R2),
      .Y2          (Y2),
      .G2          (G2),
      .walk        (walk),
      .ped_pending (ped_pending),
      .phase       (phase)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at %0t", tag, act, act, exp, exp, $time);
      end
   endtask

   // {R1,Y1,G1,R2,Y2,G2,walk} as currently driven.
   function automatic int lamps_now();
      return int'({25'd0, R1, Y1, G1, R2, Y2, G2, walk});
   endfunction

   // Required {R1,Y1,G1,R2,Y2,G2,walk} for each phase.
   function automatic int exp_lamps(input int ph);
      case (ph)
         1:       return 32'b0011000;
         2:       return 32'b0101000;
         4:       return 32'b1000010;
         5:       return 32'b1000100;
         7:       return 32'b1001001;
         default: return 32'b1001000;
      endcase
   endfunction

   // Segment monitor: closes a segment on every phase change.
   always @(negedge clk) begin
      seg_t e;
      if (rst || mon_en == 0) begin
         mon_len = 0;
      end else if (mon_len == 0) begin
         mon_phase = int'(phase);
         mon_lamps = lamps_now();
         mon_len   = 1;
      end else if (int'(phase) == mon_phase) begin
         mon_len++;
      end else begin
         if (sb.size() == 0) begin
            check("sb_underflow", sb.size(), 1);
         end else begin
            e = sb.pop_front();
            check("seg_phase", mon_phase, e.ph);
            check("seg_len", mon_len, e.len);
            check("seg_lamps", mon_lamps, exp_lamps(e.ph));
         end
         mon_phase = int'(phase);
         mon_lamps = lamps_now();
         mon_len   = 1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic push(input int ph, input int len);
      seg_t e;
      e.ph  = ph;
      e.len = len;
      sb.push_back(e);
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      check("drain_timeout", sb.size(), 0);
   endtask

   task automatic wait_phase(input int ph, input int budget);
      int n = 0;
      while (int'(phase) != ph && n < budget) begin
         tick();
         n++;
      end
      check("wait_phase", int'(phase), ph);
   endtask

   task automatic restart();
      check("sb_empty", sb.size(), 0);
      sb.delete();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; cfg_load = 1'b0; req1 = 1'b0; req2 = 1'b0; ped_req = 1'b0;
      Tgreen = 8'd0; Tyellow = 8'd0; Tallred = 8'd0; Twalk = 8'd0;
`ifdef TRAFFIC_FLASH_EN
      flash = 1'b0;
`endif
      mon_en = 1;
      tick();
      tick();
      // Reset state
      check("rst_phase", int'(phase), 0);
      check("rst_lamps", lamps_now(), 32'b1001000);
      check("rst_ped", int'(ped_pending), 0);
      rst = 1'b0;

      // No requests: INIT 2 cycles then G1 rests
      push(0, 2);
      drain(50);
      repeat (110) tick();
      check("g1_rest_phase", int'(phase), 1);
      check("g1_rest_lamps", lamps_now(), 32'b0011000);
      check("g1_rest_len", int'(mon_len >= 100), 1);

      // req2 held from reset: fixed default intervals, then alternation
      req2 = 1'b1;
      restart();
      push(0, 2); push(1, 20); push(2, 4); push(3, 2);
      drain(100);
      check("g2_lamps", lamps_now(), 32'b1000010);
      req1 = 1'b1;
      push(4, 20); push(5, 4); push(6, 2); push(1, 20); push(2, 4); push(3, 2);
      drain(200);

      // Pedestrian request during G1 with no cross traffic
      req1 = 1'b0; req2 = 1'b0;
      restart();
      push(0, 2);
      drain(50);
      ped_req = 1'b1;
      tick();
      ped_req = 1'b0;
      check("ped_latched", int'(ped_pending), 1);
      push(1, 20); push(2, 4); push(3, 2);
      wait_phase(7, 100);
      check("walk_ped_clr", int'(ped_pending), 0);
      check("walk_lamps", lamps_now(), 32'b1001001);
      ped_req = 1'b1;
      tick();
      ped_req = 1'b0;
      push(7, 10);
      drain(50);
      check("walk_exit_phase", int'(phase), 4);
      check("walk_ped_ignored", int'(ped_pending), 0);

      // New timing loaded mid-G1 takes effect only after the next all-red
      req1 = 1'b1; req2 = 1'b1;
      restart();
      push(0, 2);
      drain(50);
      Tgreen = 8'd5; Tyellow = 8'd0; Tallred = 8'd2; Twalk = 8'd10;
      cfg_load = 1'b1;
      tick();
      cfg_load = 1'b0;
      push(1, 20); push(2, 4); push(3, 2); push(4, 5); push(5, 1); push(6, 2);
      push(1, 5); push(2, 1); push(3, 2);
      drain(150);

      // Asynchronous reset in the middle of Y2 discards a pending request
      restart();
      push(0, 2); push(1, 20); push(2, 4); push(3, 2); push(4, 20);
      drain(150);
      ped_req = 1'b1;
      tick();
      ped_req = 1'b0;
      check("y2_phase", int'(phase), 5);
      check("y2_ped", int'(ped_pending), 1);
      rst = 1'b1;
      #1;
      check("arst_phase", int'(phase), 0);
      check("arst_lamps", lamps_now(), 32'b1001000);
      check("arst_ped", int'(ped_pending), 0);
      tick();
      rst = 1'b0;
      push(0, 2); push(1, 20);
      drain(100);

`ifdef TRAFFIC_FLASH_EN
      // Flash during G2: both yellows blink every 4 cycles, then INIT, G1
      req1 = 1'b0; req2 = 1'b1;
      restart();
      push(0, 2); push(1, 20); push(2, 4); push(3, 2);
      drain(100);
      mon_en = 0;
      flash = 1'b1;
      ped_req = 1'b1;
      tick();
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         check("flash_lamps", lamps_now(), (((k / 4) % 2) == 0) ? 32'b0100100 : 32'b0);
         check("flash_phase", int'(phase), 0);
         check("flash_ped", int'(ped_pending), 0);
      end
      ped_req = 1'b0;
      tick();
      flash = 1'b0;
      tick();
      mon_en = 1;
      push(0, 2); push(1, 20);
      drain(100);
`endif

      check("sb_final", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
